// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; optional hit/miss counters under ICACHE_STATS_EN.
// Latency: hit 1 cycle, miss = memory latency + 1 cycle.
// Backpressure: fetch_ready low while a line fill is outstanding; rdy=0 freezes everything.
module icache #(
   parameter int LINE_BYTES = 8,
   parameter int INDEX_BITS = 4
) (
`ifdef ICACHE_STATS_EN
   output logic [31:0]              stat_hits,
   output logic [31:0]              stat_misses,
`endif
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     fetch_req,
   input  logic [31:0]              fetch_pc,
   output logic                     fetch_ready,
   input  logic                     fetch_flush,
   output logic                     fetch_valid,
   output logic [31:0]              fetch_inst,
   output logic [31:0]              fetch_inst_pc,
   output logic                     mem_en,
   output logic [31:0]              mem_pc,
   input  logic                     mem_done,
   input  logic [LINE_BYTES*8-1:0]  mem_data
);

   localparam int OFF      = $clog2(LINE_BYTES);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 32 - OFF - INDEX_BITS;
   localparam int LW       = LINE_BYTES * 8;
   localparam logic [31:0] WMASK = 32'(LINE_BYTES / 4 - 1);

   typedef enum logic [1:0] {IDLE, MISS, DROP} state_t;

   state_t                state;
   logic                  ready_q;
   logic [31:0]           miss_pc;
   logic [LINES-1:0]      valid;
   logic [TAG_BITS-1:0]   tag_arr  [LINES];
   logic [LW-1:0]         data_arr [LINES];

   logic [INDEX_BITS-1:0] req_idx;
   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] miss_idx;
   logic [TAG_BITS-1:0]   miss_tag;
   logic                  hit;
   logic                  accept;
   logic                  fill;

   function automatic logic [31:0] sel_word(input logic [LW-1:0] line, input logic [31:0] pc);
      int w;
      w = int'((pc >> 2) & WMASK);
      return line[w*32 +: 32];
   endfunction

   assign req_idx     = fetch_pc[OFF+INDEX_BITS-1:OFF];
   assign req_tag     = fetch_pc[31:OFF+INDEX_BITS];
   assign miss_idx    = miss_pc[OFF+INDEX_BITS-1:OFF];
   assign miss_tag    = miss_pc[31:OFF+INDEX_BITS];
   assign hit         = valid[req_idx] && (tag_arr[req_idx] == req_tag);
   assign fetch_ready = ready_q && rdy;
   // A flush in the request cycle drops the request outright.
   assign accept      = fetch_ready && fetch_req && !fetch_flush;
   assign fill        = rdy && (state != IDLE) && mem_en && mem_done;

   always_ff @(posedge clk) begin
      if (fill) begin
         data_arr[miss_idx] <= mem_data;
         tag_arr[miss_idx]  <= miss_tag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         valid         <= '0;
         ready_q       <= 1'b1;
         miss_pc       <= '0;
         fetch_valid   <= 1'b0;
         fetch_inst    <= '0;
         fetch_inst_pc <= '0;
         mem_en        <= 1'b0;
         mem_pc        <= '0;
`ifdef ICACHE_STATS_EN
         stat_hits     <= '0;
         stat_misses   <= '0;
`endif
      end else if (rdy) begin
         fetch_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (hit) begin
                     fetch_valid   <= 1'b1;
                     fetch_inst    <= sel_word(data_arr[req_idx], fetch_pc);
                     fetch_inst_pc <= fetch_pc;
`ifdef ICACHE_STATS_EN
                     stat_hits     <= stat_hits + 32'd1;
`endif
                  end else begin
                     miss_pc <= fetch_pc;
                     mem_en  <= 1'b1;
                     mem_pc  <= {fetch_pc[31:OFF], {OFF{1'b0}}};
                     ready_q <= 1'b0;
                     state   <= MISS;
`ifdef ICACHE_STATS_EN
                     stat_misses <= stat_misses + 32'd1;
`endif
                  end
               end
            end
            MISS, DROP: begin
               if (mem_done) begin
                  // The burst always completes and fills; only the response is suppressed.
                  valid[miss_idx] <= 1'b1;
                  mem_en          <= 1'b0;
                  ready_q         <= 1'b1;
                  state           <= IDLE;
                  if (state == MISS && !fetch_flush) begin
                     fetch_valid   <= 1'b1;
                     fetch_inst    <= sel_word(mem_data, miss_pc);
                     fetch_inst_pc <= miss_pc;
                  end
               end else if (fetch_flush) begin
                  state <= DROP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected responses queued at stimulus time, popped on fetch_valid.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst, rdy, fetch_req, fetch_flush, mem_done;
   logic [31:0] fetch_pc;
   logic [63:0] mem_data;
   logic        fetch_ready, fetch_valid, mem_en;
   logic [31:0] fetch_inst, fetch_inst_pc, mem_pc;
`ifdef ICACHE_STATS_EN
   logic [31:0] stat_hits, stat_misses;
`endif

   icache #(.LINE_BYTES(8), .INDEX_BITS(4)) dut (
`ifdef ICACHE_STATS_EN
      .stat_hits(stat_hits),
      .stat_misses(stat_misses),
`endif
      .clk(clk),
      .rst(rst),
      .rdy(rdy),
      .fetch_req(fetch_req),
      .fetch_pc(fetch_pc),
      .fetch_ready(fetch_ready),
      .fetch_flush(fetch_flush),
      .fetch_valid(fetch_valid),
      .fetch_inst(fetch_inst),
      .fetch_inst_pc(fetch_inst_pc),
      .mem_en(mem_en),
      .mem_pc(mem_pc),
      .mem_done(mem_done),
      .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   // Memory image: distinct bytes per line, line 0x1000 holds 0x00..0x07.
   function automatic logic [7:0] mbyte(input logic [31:0] a);
      return 8'(a[7:0] + a[19:12] - 8'd1);
   endfunction

   function automatic logic [63:0] line_data(input logic [31:0] line);
      logic [63:0] d;
      for (int k = 0; k < 8; k++) d[8*k +: 8] = mbyte(line + 32'(k));
      return d;
   endfunction

   function automatic logic [31:0] exp_inst(input logic [31:0] pc);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = mbyte((pc & 32'hFFFF_FFFC) + 32'(i));
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst && fetch_valid) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_valid: got pc=%h inst=%h, required no response", fetch_inst_pc, fetch_inst);
         end else begin
            mon_e = exp_q.pop_front();
            if (fetch_inst !== mon_e.inst || fetch_inst_pc !== mon_e.pc) begin
               fails++;
               $display("FAIL response: got pc=%h inst=%h, required pc=%h inst=%h",
                        fetch_inst_pc, fetch_inst, mon_e.pc, mon_e.inst);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.inst = exp_inst(pc);
      e.pc   = pc;
      exp_q.push_back(e);
   endtask

   task automatic req(input logic [31:0] pc, input bit expect_hit);
      int n = 0;
      fetch_req = 1'b1;
      fetch_pc  = pc;
      while (!fetch_ready && n < 100) begin
         tick();
         n++;
      end
      if (n == 100) begin
         tests++;
         fails++;
         $display("FAIL req_timeout: pc=%h fetch_ready=%b, required 1", pc, fetch_ready);
      end
      if (expect_hit) push_exp(pc);
      tick();
      fetch_req = 1'b0;
      if (expect_hit) begin
         tests++;
         if (fetch_valid !== 1'b1 || mem_en !== 1'b0) begin
            fails++;
            $display("FAIL hit_latency: pc=%h valid=%b mem_en=%b, required valid=1 mem_en=0", pc, fetch_valid, mem_en);
         end
      end
   endtask

   task automatic serve(input logic [31:0] line, input int lat, input bit resp, input logic [31:0] pc);
      int n = 0;
      while (!mem_en && n < 50) begin
         tick();
         n++;
      end
      tests++;
      if (mem_en !== 1'b1 || mem_pc !== line) begin
         fails++;
         $display("FAIL mem_req: mem_en=%b mem_pc=%h, required 1 %h", mem_en, mem_pc, line);
      end
      repeat (lat) tick();
      tests++;
      if (mem_en !== 1'b1) begin
         fails++;
         $display("FAIL mem_hold: mem_en=%b before done, required 1", mem_en);
      end
      mem_done = 1'b1;
      mem_data = line_data(line);
      if (resp) push_exp(pc);
      tick();
      mem_done = 1'b0;
      mem_data = {$urandom, $urandom};
      tests++;
      if (mem_en !== 1'b0 || fetch_valid !== resp) begin
         fails++;
         $display("FAIL fill: mem_en=%b valid=%b, required mem_en=0 valid=%b", mem_en, fetch_valid, resp);
      end
   endtask

   task automatic check_drain(input string name);
      tick();
      tick();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic check_stats(input string name, input logic [31:0] h, input logic [31:0] m);
`ifdef ICACHE_STATS_EN
      tests++;
      if (stat_hits !== h || stat_misses !== m) begin
         fails++;
         $display("FAIL %s_stats: hits=%0d misses=%0d, required %0d %0d", name, stat_hits, stat_misses, h, m);
      end
`else
      if (name.len() == 0) $display("stats %0d %0d", h, m);
`endif
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick();
      tick();
      tests++;
      if (fetch_ready !== 1'b1 || fetch_valid !== 1'b0 || fetch_inst !== 32'h0 ||
          fetch_inst_pc !== 32'h0 || mem_en !== 1'b0 || mem_pc !== 32'h0) begin
         fails++;
         $display("FAIL reset: ready=%b valid=%b inst=%h ipc=%h mem_en=%b mem_pc=%h, required 1 0 0 0 0 0",
                  fetch_ready, fetch_valid, fetch_inst, fetch_inst_pc, mem_en, mem_pc);
      end
      check_stats("reset", 32'd0, 32'd0);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_miss_fill;
      req(32'h1004, 1'b0);
      serve(32'h1000, 3, 1'b1, 32'h1004);
      check_drain("miss_fill");
   endtask

   task automatic test_hit;
      req(32'h1000, 1'b1);
      check_drain("hit");
      check_stats("hit", 32'd1, 32'd1);
   endtask

   task automatic test_back_to_back;
      fetch_req = 1'b1;
      fetch_pc  = 32'h1000;
      push_exp(32'h1000);
      tick();
      tests++;
      if (fetch_valid !== 1'b1 || fetch_ready !== 1'b1) begin
         fails++;
         $display("FAIL b2b_first: valid=%b ready=%b, required 1 1", fetch_valid, fetch_ready);
      end
      fetch_pc = 32'h1004;
      push_exp(32'h1004);
      tick();
      fetch_req = 1'b0;
      tests++;
      if (fetch_valid !== 1'b1) begin
         fails++;
         $display("FAIL b2b_second: valid=%b, required 1", fetch_valid);
      end
      check_drain("b2b");
   endtask

   task automatic test_conflict;
      req(32'h1080, 1'b0);
      serve(32'h1080, 2, 1'b1, 32'h1080);
      req(32'h1000, 1'b0);
      serve(32'h1000, 1, 1'b1, 32'h1000);
      check_drain("conflict");
   endtask

   task automatic test_flush_idle;
      fetch_req   = 1'b1;
      fetch_pc    = 32'h1000;
      fetch_flush = 1'b1;
      tick();
      fetch_req   = 1'b0;
      fetch_flush = 1'b0;
      tests++;
      if (fetch_valid !== 1'b0 || mem_en !== 1'b0) begin
         fails++;
         $display("FAIL flush_idle: valid=%b mem_en=%b, required 0 0", fetch_valid, mem_en);
      end
      check_drain("flush_idle");
   endtask

   task automatic test_flush_miss;
      req(32'h2000, 1'b0);
      tick();
      fetch_flush = 1'b1;
      tick();
      fetch_flush = 1'b0;
      serve(32'h2000, 2, 1'b0, 32'h2000);
      req(32'h2000, 1'b1);
      check_drain("flush_miss");
   endtask

   task automatic test_flush_with_done;
      req(32'h2008, 1'b0);
      tick();
      fetch_flush = 1'b1;
      mem_done    = 1'b1;
      mem_data    = line_data(32'h2008);
      tick();
      fetch_flush = 1'b0;
      mem_done    = 1'b0;
      tests++;
      if (fetch_valid !== 1'b0 || mem_en !== 1'b0) begin
         fails++;
         $display("FAIL flush_done: valid=%b mem_en=%b, required 0 0", fetch_valid, mem_en);
      end
      req(32'h200C, 1'b1);
      check_drain("flush_done");
   endtask

   task automatic test_rdy_stall;
      req(32'h3004, 1'b0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (mem_en !== 1'b1 || mem_pc !== 32'h3000 || fetch_valid !== 1'b0 || fetch_ready !== 1'b0) begin
            fails++;
            $display("FAIL rdy_miss_freeze: mem_en=%b mem_pc=%h valid=%b ready=%b, required 1 3000 0 0",
                     mem_en, mem_pc, fetch_valid, fetch_ready);
         end
      end
      rdy = 1'b1;
      serve(32'h3000, 0, 1'b1, 32'h3004);
      check_drain("rdy_miss");
      rdy       = 1'b0;
      fetch_req = 1'b1;
      fetch_pc  = 32'h1000;
      #1;
      tests++;
      if (fetch_ready !== 1'b0) begin
         fails++;
         $display("FAIL rdy_idle_ready: ready=%b, required 0", fetch_ready);
      end
      tick();
      tick();
      fetch_req = 1'b0;
      rdy       = 1'b1;
      tests++;
      if (fetch_valid !== 1'b0) begin
         fails++;
         $display("FAIL rdy_idle_accept: valid=%b, required 0", fetch_valid);
      end
      check_drain("rdy_idle");
   endtask

   task automatic test_reset_mid_miss;
      req(32'h4000, 1'b0);
      tick();
      #2 rst = 1'b0;
      #1;
      tests++;
      if (mem_en !== 1'b0 || fetch_valid !== 1'b0 || fetch_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_miss: mem_en=%b valid=%b ready=%b, required 0 0 1", mem_en, fetch_valid, fetch_ready);
      end
      check_stats("reset_mid", 32'd0, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      req(32'h1000, 1'b0);
      serve(32'h1000, 1, 1'b1, 32'h1000);
      check_drain("reset_mid");
      check_stats("after_reset", 32'd0, 32'd1);
   endtask

   initial begin
      rst         = 1'b0;
      rdy         = 1'b1;
      fetch_req   = 1'b0;
      fetch_pc    = 32'h0;
      fetch_flush = 1'b0;
      mem_done    = 1'b0;
      mem_data    = 64'h0;
      test_reset();
      test_miss_fill();
      test_hit();
      test_back_to_back();
      test_conflict();
      test_flush_idle();
      test_flush_miss();
      test_flush_with_done();
      test_rdy_stall();
      test_reset_mid_miss();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

endmodule
